// File: rtl/rv_lsu_pkg.sv
// rtl/rv_lsu_pkg.sv - shared encodings for the load/store unit
package rv_lsu_pkg;

    localparam logic [1:0] LSU_SZ_B   = 2'b00;
    localparam logic [1:0] LSU_SZ_H   = 2'b01;
    localparam logic [1:0] LSU_SZ_W   = 2'b10;
    localparam logic [1:0] LSU_SZ_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/rv_lsu_lane.sv
// rtl/rv_lsu_lane.sv - byte/half lane extract with extension, and store lane merge
module rv_lsu_lane
    import rv_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign shamt   = {addr_lo_i, 3'b000};
    assign shifted = word_i >> shamt;

    always_comb begin
        load_data_o = word_i;
        case (size_i)
            LSU_SZ_B: load_data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            LSU_SZ_H: load_data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default:  load_data_o = word_i;
        endcase
    end

    // Lanes outside the mask keep the current memory contents.
    always_comb begin
        mask         = 32'h0;
        store_word_o = wdata_i;
        case (size_i)
            LSU_SZ_B: begin
                mask         = 32'h0000_00FF << shamt;
                store_word_o = (word_i & ~mask) | ((wdata_i & 32'h0000_00FF) << shamt);
            end
            LSU_SZ_H: begin
                mask         = 32'h0000_FFFF << shamt;
                store_word_o = (word_i & ~mask) | ((wdata_i & 32'h0000_FFFF) << shamt);
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - load/store unit driving a word-only data memory port
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter logic [31:0] BASE  = 32'h0000_1000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // 33-bit bounds: the top of the window may equal 2^32.
    localparam logic [32:0] WIN_LO = {1'b0, BASE};
    localparam logic [32:0] WIN_HI = {1'b0, BASE} + (33'(WORDS) << 2);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    assign req_err = (req_size == LSU_SZ_ILL)
                  || ((req_size == LSU_SZ_H) && req_addr[0])
                  || ((req_size == LSU_SZ_W) && (req_addr[1:0] != 2'b00))
                  || ({1'b0, req_addr} <  WIN_LO)
                  || ({1'b0, req_addr} >= WIN_HI);

    rv_lsu_lane u_lane (
        .word_i       (mem_rdata),
        .addr_lo_i    (addr_lo_q),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d      = req_we;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    err_d     = req_err;
                    if (req_err) begin
                        rdata_d = 32'h0;
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        // Full-word stores need no read; sub-word stores merge first.
                        if (req_we && (req_size == LSU_SZ_W)) begin
                            mem_wdata_d = req_wdata;
                            state_d     = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    mem_wdata_d = store_word;
                    state_d     = ST_WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                rdata_d = 32'h0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= LSU_SZ_B;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - self-checking bench for rv_lsu with a word-wide data memory
module tb_rv_lsu;

    localparam int unsigned WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    rv_lsu #(.WORDS(WORDS), .BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Data memory: combinational read, synchronous write.
    logic [31:0] dmem [0:WORDS-1];
    logic        init_mem;
    logic [31:0] moff;
    assign moff      = mem_addr - BASE;
    assign mem_rdata = (mem_addr >= BASE && moff < WORDS*4) ? dmem[moff[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < WORDS; i++) dmem[i] <= 32'h0;
            dmem[0] <= 32'h4000_0000;
            dmem[1] <= 32'h4040_0000;
        end else if (mem_we && mem_addr >= BASE && moff < WORDS*4) begin
            dmem[moff[11:2]] <= mem_wdata;
        end
    end

    // Reference: byte-addressed image of the window.
    logic [7:0] ref_b [0:WORDS*4-1];

    task automatic ref_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat);
        int nb;
        longint off;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = longint'(a) - longint'(BASE);
        er  = (sz == 2'd3) || (a % nb != 0) || off < 0 || off >= longint'(WORDS) * 4;
        rd  = 32'h0;
        if (er) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_b[int'(off) + i] = wd[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
        end else begin
            for (int i = 0; i < nb; i++) rd = rd | (32'(ref_b[int'(off) + i]) << (8 * i));
            if (!uns && nb == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
            if (!uns && nb == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
            lat = 2;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int wep, output logic rdy_ok);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd = 32'h0; er = 1'b0; lat = 0; wep = 0; rdy_ok = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) wep++;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            if (req_ready) rdy_ok = 1'b0;
        end
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_lat;
    } vec_t;

    vec_t tab [$];

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer, rdy_ok;
        int          lat, mlat, wep;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        we, uns;

        tab.push_back('{"lw_1004",  1'b0, 2'd2, 1'b0, 32'h1004, 32'h0,        32'h4040_0000, 1'b0, 2});
        tab.push_back('{"lb_1003",  1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        32'h0000_0040, 1'b0, 2});
        tab.push_back('{"lhu_1006", 1'b0, 2'd1, 1'b1, 32'h1006, 32'h0,        32'h0000_4040, 1'b0, 2});
        tab.push_back('{"lh_1002",  1'b0, 2'd1, 1'b0, 32'h1002, 32'h0,        32'h0000_4000, 1'b0, 2});
        tab.push_back('{"sb_1008",  1'b1, 2'd0, 1'b0, 32'h1008, 32'h1234_56FF, 32'h0,        1'b0, 3});
        tab.push_back('{"lb_1008",  1'b0, 2'd0, 1'b0, 32'h1008, 32'h0,        32'hFFFF_FFFF, 1'b0, 2});
        tab.push_back('{"lbu_1008", 1'b0, 2'd0, 1'b1, 32'h1008, 32'h0,        32'h0000_00FF, 1'b0, 2});
        tab.push_back('{"lw_1008",  1'b0, 2'd2, 1'b0, 32'h1008, 32'h0,        32'h0000_00FF, 1'b0, 2});
        tab.push_back('{"sh_1002",  1'b1, 2'd1, 1'b0, 32'h1002, 32'hABCD_1234, 32'h0,        1'b0, 3});
        tab.push_back('{"lw_1000",  1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h1234_0000, 1'b0, 2});
        tab.push_back('{"sw_100c",  1'b1, 2'd2, 1'b0, 32'h100C, 32'hDEAD_BEEF, 32'h0,        1'b0, 2});
        tab.push_back('{"lw_100c",  1'b0, 2'd2, 1'b0, 32'h100C, 32'h0,        32'hDEAD_BEEF, 1'b0, 2});
        tab.push_back('{"lw_1002",  1'b0, 2'd2, 1'b0, 32'h1002, 32'h0,        32'h0,         1'b1, 1});
        tab.push_back('{"sh_1001",  1'b1, 2'd1, 1'b0, 32'h1001, 32'h5555,     32'h0,         1'b1, 1});
        tab.push_back('{"ill_1000", 1'b0, 2'd3, 1'b0, 32'h1000, 32'h0,        32'h0,         1'b1, 1});
        tab.push_back('{"lw_0ffc",  1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0,        32'h0,         1'b1, 1});
        tab.push_back('{"lw_2000",  1'b0, 2'd2, 1'b0, 32'h2000, 32'h0,        32'h0,         1'b1, 1});
        tab.push_back('{"lw_1ffc",  1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0,        32'h0,         1'b0, 2});

        for (int i = 0; i < WORDS * 4; i++) ref_b[i] = 8'h0;
        ref_b[3] = 8'h40; ref_b[6] = 8'h40; ref_b[7] = 8'h40;

        rst = 1'b1; init_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        chk("rst_ready",      {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_mem_we",     {31'h0, mem_we},     32'h0);
        chk("rst_mem_addr",   mem_addr,            32'h0);
        chk("rst_mem_wdata",  mem_wdata,           32'h0);
        @(negedge clk) rst = 1'b0;

        foreach (tab[i]) begin
            do_req(tab[i].we, tab[i].sz, tab[i].uns, tab[i].addr, tab[i].wdata, rd, er, lat, wep, rdy_ok);
            ref_access(tab[i].we, tab[i].sz, tab[i].uns, tab[i].addr, tab[i].wdata, mrd, mer, mlat);
            chk({tab[i].nm, "_rdata"}, rd, tab[i].exp_rd);
            chk({tab[i].nm, "_err"}, {31'h0, er}, {31'h0, tab[i].exp_er});
            chk({tab[i].nm, "_lat"}, lat, tab[i].exp_lat);
            chk({tab[i].nm, "_wepulse"}, wep, (tab[i].we && !tab[i].exp_er) ? 1 : 0);
            chk({tab[i].nm, "_busy"}, {31'h0, rdy_ok}, 32'h1);
            chk({tab[i].nm, "_model"}, mrd, tab[i].exp_rd);
        end

        // Reset during the read phase of a byte store must drop the store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h1008; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rst_mid_in_read", {31'h0, req_ready}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_we",    {31'h0, mem_we},    32'h0);
        @(negedge clk) rst = 1'b0;
        wep = 0; lat = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) lat++;
            if (mem_we) wep++;
        end
        chk("rst_mid_no_resp", lat, 0);
        chk("rst_mid_no_we",   wep, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, rd, er, lat, wep, rdy_ok);
        chk("rst_mid_lw_1008", rd, 32'h0000_00FF);

        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE + WORDS * 4 - 4 + $urandom_range(0, 7);
                2:       a = BASE - $urandom_range(1, 4);
                default: a = BASE + $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0]   = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(we, sz, uns, a, $urandom, rd, er, lat, wep, rdy_ok);
            ref_access(we, sz, uns, a, req_wdata, mrd, mer, mlat);
            chk("rnd_rdata", rd, mrd);
            chk("rnd_err", {31'h0, er}, {31'h0, mer});
            chk("rnd_lat", lat, mlat);
            chk("rnd_wepulse", wep, (we && !mer) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
